pll_vga_lock_ctrl: RTL and testbench
====================================

# pll_vga_lock_ctrl

Supervisor for the VGA pixel-clock PLL. It drives the PLL's `rst` input and consumes its asynchronous `locked` output. It sequences PLL reset pulses, qualifies lock over a stability window, and retries on lock timeout. It reports a clean `ready` for releasing the 33 MHz pixel-domain reset, plus lock-loss statistics. It runs on the 50 MHz reference clock, alongside the PLL instance in the GHRD top.

## Interface
- `RST_PULSE_CYCLES`, default 10: refclk cycles `pll_rst` is held high per reset pulse (≥1).
- `LOCK_TIMEOUT_CYCLES`, default 50000: cycles in WAIT_LOCK before a retry (1 ms at 50 MHz).
- `LOCK_STABLE_CYCLES`, default 1024: consecutive synchronized-locked cycles required before `ready`.
- `MAX_RETRIES`, default 3: retries after the initial pulse before FAIL.
- `CNT_W`, default 8: width of `loss_count`.
- `refclk` in 1: the single clock. All logic is on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `locked` in 1: PLL lock, asynchronous to `refclk`.
- `clear_stats` in 1: synchronous clear of `loss_count`.
- `pll_rst` out 1: reset to the PLL.
- `ready` out 1: the PLL is locked and stable.
- `lock_lost` out 1: one-cycle pulse on loss of lock while in RUN.
- `fail` out 1: retries exhausted. Sticky until `rst`.
- `retry_count` out 2: retries used in the current bring-up.
- `loss_count` out CNT_W: lock losses from RUN, saturating.

## Operation
- `locked` passes through a 2-FF synchronizer to give `locked_s`. No other path uses raw `locked`.
- FSM states: RESET_PLL, WAIT_LOCK, STABILIZE, RUN, FAIL. One timer, cleared on every state change.
- **RESET_PLL:** `pll_rst`=1. After RST_PULSE_CYCLES cycles, go to WAIT_LOCK.
- **WAIT_LOCK:**
  - If `locked_s`=1, go to STABILIZE.
  - Else, when the timer reaches LOCK_TIMEOUT_CYCLES−1:
    - if `retry_count`==MAX_RETRIES, go to FAIL;
    - otherwise increment `retry_count` and go to RESET_PLL.
- **STABILIZE:**
  - If `locked_s`=0, return to WAIT_LOCK with a fresh timeout. There is no retry increment and no PLL reset.
  - After LOCK_STABLE_CYCLES cycles with `locked_s`=1, go to RUN and clear `retry_count`.
- **RUN:** `ready`=1. If `locked_s`=0:
  - pulse `lock_lost` for one cycle;
  - increment `loss_count`, saturating at 2^CNT_W−1;
  - clear `retry_count`;
  - go to RESET_PLL.
- **FAIL:** `pll_rst`=0, `fail`=1, `ready`=0. Only `rst` exits this state.
- `clear_stats` zeroes `loss_count` on the next edge. If it coincides with an increment, the clear wins and the result is 0.
- `pll_rst`, `ready` and `fail` are registered state decodes and are glitch-free.

## Timing
- Reset values while `rst`=1, applied asynchronously:
  - state RESET_PLL, `pll_rst`=1;
  - `ready`=0, `lock_lost`=0, `fail`=0;
  - `retry_count`=0, `loss_count`=0, timer 0, synchronizer FFs 0.
- After `rst` deasserts, `pll_rst` stays high for exactly RST_PULSE_CYCLES edges.
- Lock latency: STABILIZE is entered 2 edges after the first edge that samples `locked`=1. `ready` rises LOCK_STABLE_CYCLES edges after that, for a total of 2+LOCK_STABLE_CYCLES.
- Loss latency: `ready` falls, `lock_lost` pulses and `pll_rst` rises on the 3rd edge after `locked` falls.
- Spacing of retry pulses: pulse starts are RST_PULSE_CYCLES+LOCK_TIMEOUT_CYCLES cycles apart.
- Reset mid-operation: asynchronous. `pll_rst`=1 and `ready`=0 take effect immediately and the statistics are lost.

## Structure
- Package `pll_vga_pkg`:
  - state enum `lock_state_t`;
  - timer width constant `$clog2(max(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES))`, computed locally from the parameters.
- Sub-module `sync_2ff` (1-bit, reset to 0), instantiated once for `locked`.

## Test plan
Common parameters: RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2, CNT_W=2.
- **Normal bring-up:** release `rst` and raise `locked` 5 cycles after `pll_rst` falls → `pll_rst` high exactly 4 cycles, and `ready` rises 10 edges after the first edge sampling `locked`=1.
- **Timeout:** `locked` held 0 → three `pll_rst` pulses of 4 cycles each, starting 24 cycles apart. Then `fail`=1, `pll_rst`=0 and `retry_count`=2, all held.
- **Glitch in STABILIZE:** `locked` drops for 1 cycle after 5 stable cycles → no `ready`, no `pll_rst` pulse. `ready` rises 10 edges after the first edge re-sampling `locked`=1.
- **Loss in RUN:** drop `locked` → on the 3rd edge `ready`=0, `lock_lost`=1 for 1 cycle, `loss_count` 0→1, and `pll_rst` goes high for 4 cycles. After re-lock, `ready` returns.
- **Saturation and clear:** 4 losses → `loss_count`=3 with no wrap. `clear_stats` coincident with a 5th loss → `loss_count`=0.
- **Async reset in RUN:** assert `rst` between edges → `ready`=0 and `pll_rst`=1 before the next edge, and all counters read 0.

Source files
------------

// File: rtl/pll_vga_pkg.sv
// Shared types and helpers for the VGA pixel-clock PLL supervisor.
package pll_vga_pkg;

    typedef enum logic [2:0] {
        StResetPll,
        StWaitLock,
        StStabilize,
        StRun,
        StFail
    } lock_state_t;

    // Timer width able to hold the largest (cycles - 1) of the three windows.
    function automatic int unsigned timer_width(input int unsigned a,
                                                input int unsigned b,
                                                input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/pll_vga_lock_ctrl_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the raw level through two flops; both clear on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_vga_lock_ctrl.sv
// Supervisor for the VGA pixel-clock PLL: pulses the PLL reset, qualifies
// lock over a stability window, retries on timeout and counts lock losses.
module pll_vga_lock_ctrl
    import pll_vga_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYCLES    = 10,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned CNT_W               = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             locked,
    input  logic             clear_stats,
    output logic             pll_rst,
    output logic             ready,
    output logic             lock_lost,
    output logic             fail,
    output logic [1:0]       retry_count,
    output logic [CNT_W-1:0] loss_count
);

    localparam int unsigned TW =
        timer_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);

    localparam logic [TW-1:0]    RST_LAST     = TW'(RST_PULSE_CYCLES - 1);
    localparam logic [TW-1:0]    TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]    STABLE_LAST  = TW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);
    localparam logic [CNT_W-1:0] LOSS_MAX     = '1;

    lock_state_t      state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [1:0]       retry_q, retry_d;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic             lost_d;
    logic             locked_s;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (locked),
        .q   (locked_s)
    );

    // Next-state, retry and loss bookkeeping.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        lost_d  = 1'b0;
        unique case (state_q)
            StResetPll: begin
                if (timer_q == RST_LAST) state_d = StWaitLock;
            end
            StWaitLock: begin
                if (locked_s) begin
                    state_d = StStabilize;
                end else if (timer_q == TIMEOUT_LAST) begin
                    if (retry_q == RETRY_MAX) begin
                        state_d = StFail;
                    end else begin
                        retry_d = retry_q + 2'd1;
                        state_d = StResetPll;
                    end
                end
            end
            StStabilize: begin
                // A dropout only restarts the wait; the PLL is not reset.
                if (!locked_s) begin
                    state_d = StWaitLock;
                end else if (timer_q == STABLE_LAST) begin
                    state_d = StRun;
                    retry_d = 2'd0;
                end
            end
            StRun: begin
                if (!locked_s) begin
                    lost_d  = 1'b1;
                    retry_d = 2'd0;
                    state_d = StResetPll;
                end
            end
            StFail: begin
                state_d = StFail;
            end
            default: begin
                state_d = StResetPll;
            end
        endcase

        // Timer restarts on every state change and idles in RUN/FAIL.
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (state_q == StRun || state_q == StFail) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + 1'b1;
        end

        // Clear has priority over a coincident increment.
        if (clear_stats) begin
            loss_d = '0;
        end else if (lost_d && loss_q != LOSS_MAX) begin
            loss_d = loss_q + 1'b1;
        end else begin
            loss_d = loss_q;
        end
    end

    // State, counters and registered output decodes.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= StResetPll;
            timer_q   <= '0;
            retry_q   <= 2'd0;
            loss_q    <= '0;
            pll_rst   <= 1'b1;
            ready     <= 1'b0;
            lock_lost <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            pll_rst   <= (state_d == StResetPll);
            ready     <= (state_d == StRun);
            lock_lost <= lost_d;
            fail      <= (state_d == StFail);
        end
    end

    assign retry_count = retry_q;
    assign loss_count  = loss_q;

endmodule

// File: tb/tb_pll_vga_lock_ctrl.sv
// Self-checking bench for pll_vga_lock_ctrl using a queue of expected results.
module tb_pll_vga_lock_ctrl;

    localparam int unsigned RP = 4;
    localparam int unsigned TO = 20;
    localparam int unsigned ST = 8;
    localparam int unsigned MR = 2;
    localparam int unsigned CW = 2;

    logic          refclk = 1'b0;
    logic          rst = 1'b1;
    logic          locked = 1'b0;
    logic          clear_stats = 1'b0;
    logic          pll_rst, ready, lock_lost, fail;
    logic [1:0]    retry_count;
    logic [CW-1:0] loss_count;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];
    int exp_loss = 0;

    pll_vga_lock_ctrl #(
        .RST_PULSE_CYCLES    (RP),
        .LOCK_TIMEOUT_CYCLES (TO),
        .LOCK_STABLE_CYCLES  (ST),
        .MAX_RETRIES         (MR),
        .CNT_W               (CW)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .locked      (locked),
        .clear_stats (clear_stats),
        .pll_rst     (pll_rst),
        .ready       (ready),
        .lock_lost   (lock_lost),
        .fail        (fail),
        .retry_count (retry_count),
        .loss_count  (loss_count)
    );

    always #5 refclk = ~refclk;

    function automatic logic pick(input int sel);
        case (sel)
            0:       return pll_rst;
            1:       return ready;
            2:       return fail;
            default: return lock_lost;
        endcase
    endfunction

    // Edges elapsed until the selected output equals val; -1 if the budget runs out.
    task automatic wait_level(input int sel, input logic val, input int budget,
                              output int edges);
        edges = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge refclk);
            if (pick(sel) === val) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int e, x;
        rst = 1'b1;
        locked = 1'b0;
        clear_stats = 1'b0;
        repeat (2) @(negedge refclk);
        n_cmp++;
        if ({pll_rst, ready, lock_lost, fail, retry_count, loss_count} !== 8'b1000_0000) begin
            n_bad++;
            $display("FAIL reset_state: got %b want 10000000",
                     {pll_rst, ready, lock_lost, fail, retry_count, loss_count});
        end
        rst = 1'b0;
        exp_q.push_back(RP);
        wait_level(0, 1'b0, 20, e);
        x = exp_q.pop_front();
        n_cmp++;
        if (e !== x) begin
            n_bad++;
            $display("FAIL rst_pulse_len: got %0d want %0d", e, x);
        end
    endtask

    task automatic test_bring_up();
        int e, x;
        repeat (5) @(negedge refclk);
        locked = 1'b1;
        exp_q.push_back(2 + ST + 1);
        wait_level(1, 1'b1, 40, e);
        x = exp_q.pop_front();
        n_cmp++;
        if (e !== x) begin
            n_bad++;
            $display("FAIL bringup_ready_latency: got %0d want %0d", e, x);
        end
        n_cmp++;
        if ({pll_rst, fail, retry_count} !== 4'b0000) begin
            n_bad++;
            $display("FAIL bringup_flags: got %b want 0000", {pll_rst, fail, retry_count});
        end
    endtask

    task automatic test_glitch();
        int e, x;
        logic saw_rst;
        rst = 1'b1;
        locked = 1'b0;
        @(negedge refclk);
        rst = 1'b0;
        exp_loss = 0;
        wait_level(0, 1'b0, 20, e);
        repeat (5) @(negedge refclk);
        locked = 1'b1;
        repeat (5) @(negedge refclk);
        locked = 1'b0;
        @(negedge refclk);
        locked = 1'b1;
        exp_q.push_back(2 + ST + 1);
        saw_rst = 1'b0;
        e = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge refclk);
            if (pll_rst) saw_rst = 1'b1;
            if (ready) begin
                e = i;
                break;
            end
        end
        x = exp_q.pop_front();
        n_cmp++;
        if (e !== x) begin
            n_bad++;
            $display("FAIL glitch_ready_latency: got %0d want %0d", e, x);
        end
        n_cmp++;
        if (saw_rst !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch_no_pll_rst: got %b want 0", saw_rst);
        end
    endtask

    task automatic test_loss();
        int e, x;
        locked = 1'b0;
        repeat (2) @(negedge refclk);
        n_cmp++;
        if ({ready, lock_lost, pll_rst} !== 3'b100) begin
            n_bad++;
            $display("FAIL loss_edge2: got %b want 100", {ready, lock_lost, pll_rst});
        end
        @(negedge refclk);
        exp_loss = (exp_loss == 3) ? 3 : exp_loss + 1;
        exp_q.push_back({1'b0, 1'b1, 1'b1, 2'(exp_loss)});
        x = exp_q.pop_front();
        n_cmp++;
        if ({ready, lock_lost, pll_rst, loss_count} !== 5'(x)) begin
            n_bad++;
            $display("FAIL loss_edge3: got %b want %b",
                     {ready, lock_lost, pll_rst, loss_count}, 5'(x));
        end
        @(negedge refclk);
        n_cmp++;
        if (lock_lost !== 1'b0) begin
            n_bad++;
            $display("FAIL loss_pulse_width: got %b want 0", lock_lost);
        end
        exp_q.push_back(RP - 1);
        wait_level(0, 1'b0, 20, e);
        x = exp_q.pop_front();
        n_cmp++;
        if (e !== x) begin
            n_bad++;
            $display("FAIL loss_pll_rst_tail: got %0d want %0d", e, x);
        end
        locked = 1'b1;
        exp_q.push_back(2 + ST + 1);
        wait_level(1, 1'b1, 40, e);
        x = exp_q.pop_front();
        n_cmp++;
        if (e !== x) begin
            n_bad++;
            $display("FAIL loss_relock_latency: got %0d want %0d", e, x);
        end
    endtask

    task automatic test_async_reset();
        int e, x;
        @(posedge refclk);
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({pll_rst, ready, lock_lost, fail, retry_count, loss_count} !== 8'b1000_0000) begin
            n_bad++;
            $display("FAIL async_reset_state: got %b want 10000000",
                     {pll_rst, ready, lock_lost, fail, retry_count, loss_count});
        end
        exp_loss = 0;
        @(negedge refclk);
        rst = 1'b0;
        // locked stays high: lock is seen as soon as WAIT_LOCK is entered.
        exp_q.push_back(RP + 1 + ST);
        wait_level(1, 1'b1, 40, e);
        x = exp_q.pop_front();
        n_cmp++;
        if (e !== x) begin
            n_bad++;
            $display("FAIL async_rebringup_latency: got %0d want %0d", e, x);
        end
    endtask

    task automatic test_saturation();
        int e, x;
        for (int k = 0; k < 4; k++) begin
            locked = 1'b0;
            repeat (3) @(negedge refclk);
            exp_loss = (exp_loss == 3) ? 3 : exp_loss + 1;
            exp_q.push_back(exp_loss);
            x = exp_q.pop_front();
            n_cmp++;
            if ({lock_lost, loss_count} !== {1'b1, 2'(x)}) begin
                n_bad++;
                $display("FAIL sat_loss_%0d: got lost=%b cnt=%0d want lost=1 cnt=%0d",
                         k, lock_lost, loss_count, x);
            end
            wait_level(0, 1'b0, 20, e);
            locked = 1'b1;
            wait_level(1, 1'b1, 40, e);
        end
        locked = 1'b0;
        repeat (2) @(negedge refclk);
        clear_stats = 1'b1;
        @(negedge refclk);
        clear_stats = 1'b0;
        exp_loss = 0;
        exp_q.push_back(exp_loss);
        x = exp_q.pop_front();
        n_cmp++;
        if ({lock_lost, loss_count} !== {1'b1, 2'(x)}) begin
            n_bad++;
            $display("FAIL clear_wins: got lost=%b cnt=%0d want lost=1 cnt=%0d",
                     lock_lost, loss_count, x);
        end
    endtask

    task automatic test_timeout();
        int x;
        logic prev_rst, prev_fail;
        rst = 1'b1;
        locked = 1'b0;
        repeat (2) @(negedge refclk);
        rst = 1'b0;
        // Edge times of pll_rst fall/rise and the fail rise, relative to release.
        exp_q.push_back(RP);
        exp_q.push_back(RP + TO);
        exp_q.push_back(2 * RP + TO);
        exp_q.push_back(2 * (RP + TO));
        exp_q.push_back(3 * RP + 2 * TO);
        exp_q.push_back(3 * (RP + TO));
        prev_rst = 1'b1;
        prev_fail = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge refclk);
            if (pll_rst !== prev_rst || (fail === 1'b1 && prev_fail === 1'b0)) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL timeout_extra_event: got edge at %0d want none", i);
                end else begin
                    x = exp_q.pop_front();
                    if (i !== x) begin
                        n_bad++;
                        $display("FAIL timeout_event_time: got %0d want %0d", i, x);
                    end
                end
            end
            if (i == RP + TO + 1) begin
                n_cmp++;
                if (retry_count !== 2'd1) begin
                    n_bad++;
                    $display("FAIL timeout_retry1: got %0d want 1", retry_count);
                end
            end
            prev_rst = pll_rst;
            prev_fail = fail;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL timeout_missing_events: got %0d left want 0", exp_q.size());
            exp_q.delete();
        end
        n_cmp++;
        if ({fail, pll_rst, ready, retry_count} !== 5'b10010) begin
            n_bad++;
            $display("FAIL fail_held: got %b want 10010", {fail, pll_rst, ready, retry_count});
        end
    endtask

    initial begin
        test_reset();
        test_bring_up();
        test_glitch();
        test_loss();
        test_async_reset();
        test_saturation();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
